// File: rtl/sara_pkg.sv
// Shared types and constants for the variable-latency SARA-DAR adder.
package sara_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    CORR = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_APPROX  = 2'd0;
  localparam logic [1:0] MODE_EXACT   = 2'd1;
  localparam logic [1:0] MODE_CORRECT = 2'd2;

endpackage

// File: rtl/sara_dar_core.sv
// Combinational SARA-DAR datapath: approximate and exact sums plus per-boundary error flags.
module sara_dar_core #(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned GROUPSIZE = 8,
  parameter int unsigned WINDOW    = 2
) (
  input  logic [SIZE-1:0]           a,
  input  logic [SIZE-1:0]           b,
  input  logic                      cin,
  input  logic                      cos,
  output logic [SIZE-1:0]           sum_a,
  output logic                      cout_a,
  output logic [SIZE-1:0]           sum_x,
  output logic                      cout_x,
  output logic [SIZE/GROUPSIZE-1:0] err_vec
);

  localparam int unsigned NB = SIZE / GROUPSIZE;

  logic [SIZE:0]      full;
  logic [GROUPSIZE:0] grp;
  logic               c;
  logic               gb;
  logic               cb;

  assign full   = {1'b0, a} + {1'b0, b} + (SIZE+1)'(cin);
  assign sum_x  = full[SIZE-1:0];
  assign cout_x = full[SIZE];

  // err_vec[k-1] flags boundary k; err_vec[NB-1] flags a wrong generate-based carry out.
  always_comb begin
    sum_a   = '0;
    err_vec = '0;
    gb      = 1'b0;
    cb      = 1'b0;
    grp     = {1'b0, a[GROUPSIZE-1:0]} + {1'b0, b[GROUPSIZE-1:0]} + (GROUPSIZE+1)'(cin);
    sum_a[GROUPSIZE-1:0] = grp[GROUPSIZE-1:0];
    c       = grp[GROUPSIZE];
    for (int k = 1; k < NB; k++) begin
      if (&(a[k*GROUPSIZE +: WINDOW] ^ b[k*GROUPSIZE +: WINDOW])) begin
        gb = a[k*GROUPSIZE-1] & b[k*GROUPSIZE-1];
        // exact carry into bit b recovered from the exact sum bit
        cb = full[k*GROUPSIZE] ^ a[k*GROUPSIZE] ^ b[k*GROUPSIZE];
        err_vec[k-1] = gb ^ cb;
        c = gb;
      end
      grp = {1'b0, a[k*GROUPSIZE +: GROUPSIZE]} + {1'b0, b[k*GROUPSIZE +: GROUPSIZE]}
          + (GROUPSIZE+1)'(c);
      sum_a[k*GROUPSIZE +: GROUPSIZE] = grp[GROUPSIZE-1:0];
      c = grp[GROUPSIZE];
    end
    cout_a = cos ? c : (a[SIZE-1] & b[SIZE-1]);
    err_vec[NB-1] = !cos && ((a[SIZE-1] & b[SIZE-1]) != full[SIZE]);
  end

endmodule

// File: rtl/sara_dar_vl.sv
// Variable-latency SARA-DAR adder with handshakes, optional correction and error counter.
module sara_dar_vl
  import sara_pkg::*;
#(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned GROUPSIZE = 8,
  parameter int unsigned WINDOW    = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  A,
  input  logic [SIZE-1:0]  B,
  input  logic             CIN,
  input  logic [1:0]       mode,
  input  logic             carryoutselect,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  SUM,
  output logic             COUT,
  output logic             out_exact,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned NB = SIZE / GROUPSIZE;

  if ((SIZE % GROUPSIZE) != 0 || WINDOW < 2 || WINDOW > GROUPSIZE) begin : g_bad_params
    $error("sara_dar_vl: illegal SIZE/GROUPSIZE/WINDOW combination");
  end

  state_t          state;
  state_t          state_nx;
  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_b;
  logic            op_cin;
  logic            op_cos;
  logic [1:0]      op_mode;

  logic [SIZE-1:0] sum_a;
  logic [SIZE-1:0] sum_x;
  logic            cout_a;
  logic            cout_x;
  logic [NB-1:0]   err_vec;
  logic            err;
  logic            approx_ok;
  logic            accept;
  logic            load_approx;
  logic            load_exact;

  sara_dar_core #(
    .SIZE      (SIZE),
    .GROUPSIZE (GROUPSIZE),
    .WINDOW    (WINDOW)
  ) u_core (
    .a       (op_a),
    .b       (op_b),
    .cin     (op_cin),
    .cos     (op_cos),
    .sum_a   (sum_a),
    .cout_a  (cout_a),
    .sum_x   (sum_x),
    .cout_x  (cout_x),
    .err_vec (err_vec)
  );

  assign err       = |err_vec;
  assign approx_ok = (op_mode == MODE_APPROX) || ((op_mode == MODE_CORRECT) && !err);
  assign accept    = in_valid & in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = EVAL;
      EVAL: state_nx = approx_ok ? OUT : CORR;
      CORR: state_nx = OUT;
      OUT:  if (out_ready) state_nx = in_valid ? EVAL : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and load controls decoded from state
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    load_approx = 1'b0;
    load_exact  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      EVAL: load_approx = approx_ok;
      CORR: load_exact = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Operand capture; mode 3 folds to EXACT
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_cin  <= 1'b0;
      op_cos  <= 1'b0;
      op_mode <= MODE_APPROX;
    end else if (accept) begin
      op_a    <= A;
      op_b    <= B;
      op_cin  <= CIN;
      op_cos  <= carryoutselect;
      op_mode <= (mode == 2'd3) ? MODE_EXACT : mode;
    end
  end

  // Result registers, held while OUT waits for out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      SUM       <= '0;
      COUT      <= 1'b0;
      out_exact <= 1'b0;
      out_err   <= 1'b0;
    end else if (load_approx) begin
      SUM       <= sum_a;
      COUT      <= cout_a;
      out_exact <= !err;
      out_err   <= err;
    end else if (load_exact) begin
      SUM       <= sum_x;
      COUT      <= cout_x;
      out_exact <= 1'b1;
      out_err   <= err;
    end
  end

  // Saturating count of delivered erroneous results
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sara_dar_vl.sv
// Directed bench for sara_dar_vl: latency, correction, backpressure, reset abort and counter saturation.
module tb_sara_dar_vl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] A, B, SUM;
  logic        CIN, carryoutselect, COUT, out_exact, out_err;
  logic [1:0]  mode;
  logic [15:0] err_count;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [15:0] SUM2;
  logic        COUT2, exact2, err2;
  logic [3:0]  err_count2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sara_dar_vl #(.SIZE(16), .GROUPSIZE(8), .WINDOW(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CIN(CIN), .mode(mode), .carryoutselect(carryoutselect),
    .out_valid(out_valid), .out_ready(out_ready), .SUM(SUM), .COUT(COUT),
    .out_exact(out_exact), .out_err(out_err), .err_count(err_count)
  );

  sara_dar_vl #(.SIZE(16), .GROUPSIZE(8), .WINDOW(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(A), .B(B), .CIN(CIN), .mode(mode), .carryoutselect(carryoutselect),
    .out_valid(out_valid2), .out_ready(out_ready2), .SUM(SUM2), .COUT(COUT2),
    .out_exact(exact2), .out_err(err2), .err_count(err_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After the accept edge: out_valid low until lat-1 edges later, then result checked
  task automatic wait_result(input string tag, input int lat, input logic [15:0] e_sum,
                             input logic e_cout, input logic e_exact, input logic e_err);
    for (int n = 1; n < lat; n++) begin
      check({tag, "_early_valid"}, out_valid, 0);
      tick();
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, SUM, e_sum);
    check({tag, "_cout"}, COUT, e_cout);
    check({tag, "_exact"}, out_exact, e_exact);
    check({tag, "_err"}, out_err, e_err);
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [1:0] m, input logic cos, input int lat,
                     input logic [15:0] e_sum, input logic e_cout,
                     input logic e_exact, input logic e_err);
    check({tag, "_in_ready"}, in_ready, 1);
    A = a; B = b; CIN = 1'b0; mode = m; carryoutselect = cos;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    A = ~a; B = ~b; mode = ~m; carryoutselect = ~cos;
    wait_result(tag, lat, e_sum, e_cout, e_exact, e_err);
  endtask

  task automatic handshake(input string tag, input logic [15:0] e_count);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 0);
    check({tag, "_err_count"}, err_count, e_count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    A = '0; B = '0; CIN = 1'b0; mode = 2'd0; carryoutselect = 1'b1;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", SUM, 0);
    check("rst_cout", COUT, 0);
    check("rst_exact", out_exact, 0);
    check("rst_err", out_err, 0);
    check("rst_err_count", err_count, 0);
    rst = 1'b0;
    tick();

    run("approx_err", 16'h03FF, 16'h0001, 2'd0, 1'b1, 2, 16'h0300, 1'b0, 1'b0, 1'b1);
    handshake("approx_err", 16'd1);
    run("correct", 16'h03FF, 16'h0001, 2'd2, 1'b1, 3, 16'h0400, 1'b0, 1'b1, 1'b1);
    handshake("correct", 16'd2);
    run("fast", 16'h1234, 16'h0101, 2'd2, 1'b1, 2, 16'h1335, 1'b0, 1'b1, 1'b0);
    handshake("fast", 16'd2);
    run("gen_cout_err", 16'hC000, 16'h4000, 2'd0, 1'b0, 2, 16'h0000, 1'b0, 1'b0, 1'b1);
    handshake("gen_cout_err", 16'd3);
    run("gen_cout_ok", 16'h8000, 16'h8000, 2'd0, 1'b0, 2, 16'h0000, 1'b1, 1'b1, 1'b0);
    handshake("gen_cout_ok", 16'd3);
    run("mode3", 16'h03FF, 16'h0001, 2'd3, 1'b1, 3, 16'h0400, 1'b0, 1'b1, 1'b1);
    handshake("mode3", 16'd4);

    // Backpressure then same-edge handshake and reaccept
    run("bp_first", 16'h1234, 16'h0101, 2'd0, 1'b1, 2, 16'h1335, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) begin
      check("bp_stall_in_ready", in_ready, 0);
      check("bp_stall_valid", out_valid, 1);
      check("bp_stall_sum", SUM, 16'h1335);
      tick();
    end
    A = 16'hFFFF; B = 16'h0001; CIN = 1'b0; mode = 2'd1; carryoutselect = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_in_ready_follows", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; A = 16'h0000; B = 16'h0000; mode = 2'd0;
    check("bp_count_after_first", err_count, 16'd4);
    wait_result("bp_second", 3, 16'h0000, 1'b1, 1'b1, 1'b1);
    handshake("bp_second", 16'd5);

    // Reset while in CORR aborts the operation
    A = 16'h03FF; B = 16'h0001; mode = 2'd2; carryoutselect = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("rst_mid_pre_valid", out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_sum", SUM, 0);
    check("rst_mid_err_count", err_count, 0);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("rst_mid_no_result", out_valid, 0);
    end

    // Counter saturation on the CNT_W=4 instance
    A = 16'h03FF; B = 16'h0001; CIN = 1'b0; mode = 2'd0; carryoutselect = 1'b1;
    in_valid2 = 1'b1; out_ready2 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cnt = 0;
      while (!out_valid2 && cnt < 10) begin
        tick();
        cnt++;
      end
      check("sat_valid", out_valid2, 1);
      check("sat_count", err_count2, (i > 15) ? 15 : i);
      check("sat_sum", SUM2, 16'h0300);
      check("sat_flags", {COUT2, exact2, err2, in_ready2}, 4'b0011);
      if (i == 16) in_valid2 = 1'b0;
      tick();
    end
    check("sat_final_count", err_count2, 4'd15);
    tick();
    check("sat_idle", out_valid2, 0);
    check("sat_hold_count", err_count2, 4'd15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
